// File: rtl/zxvga_pkg.sv
// Shared ZX VGA timing constants and front-porch classification helpers.
// Used by both the porch generator and the porch detector.
package zxvga_pkg;

    localparam int FP_W = 11;

    localparam logic [2:0] TIMING_48K     = 3'b000;
    localparam logic [2:0] TIMING_ALT     = 3'b010;
    localparam logic [2:0] TIMING_UNKNOWN = 3'b111;

    localparam logic [FP_W-1:0] FP_48K = 11'd48;
    localparam logic [FP_W-1:0] FP_ALT = 11'd64;
    localparam logic [FP_W-1:0] FP_MAX = 11'd2047;

    typedef enum logic [1:0] {
        WAIT_ACTIVE = 2'd0,
        ACTIVE      = 2'd1,
        PORCH       = 2'd2,
        SYNC        = 2'd3
    } porch_state_t;

    function automatic logic within_tol(input logic [FP_W-1:0] value,
                                        input logic [FP_W-1:0] nominal,
                                        input logic signed [FP_W+1:0] tol);
        logic signed [FP_W+1:0] diff;
        logic signed [FP_W+1:0] mag;
        diff = $signed({2'b00, value}) - $signed({2'b00, nominal});
        mag  = (diff < 0) ? -diff : diff;
        return (mag <= tol);
    endfunction

    // A saturated count means no sync arrived in range, so it never matches a class.
    function automatic logic [2:0] classify_fp(input logic [FP_W-1:0] fp,
                                               input logic signed [FP_W+1:0] tol);
        if (fp == FP_MAX)
            return TIMING_UNKNOWN;
        if (within_tol(fp, FP_48K, tol))
            return TIMING_48K;
        if (within_tol(fp, FP_ALT, tol))
            return TIMING_ALT;
        return TIMING_UNKNOWN;
    endfunction

endpackage

// File: rtl/zxvga_lock_filter.sv
// Debounces per-line timing classes: declares lock after LOCK_LINES
// consecutive identical known classes and reports changes of the locked class.
module zxvga_lock_filter
    import zxvga_pkg::*;
#(
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cls,
    input  logic       cls_vld,
    input  logic       clear,
    output logic [2:0] machine_timing,
    output logic       locked,
    output logic       changed
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_LINES);

    logic [2:0] prev_cls;
    logic [3:0] match_cnt;
    logic [3:0] match_nxt;
    logic       cls_known;
    logic       lock_hit;

    always_comb begin
        cls_known = (cls != TIMING_UNKNOWN);
        match_nxt = 4'd0;
        if (cls_known) begin
            if (cls != prev_cls)
                match_nxt = 4'd1;
            else if (match_cnt == 4'd15)
                match_nxt = match_cnt;
            else
                match_nxt = match_cnt + 4'd1;
        end
        lock_hit = (match_nxt >= LOCK_N);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cls       <= TIMING_UNKNOWN;
            match_cnt      <= 4'd0;
            machine_timing <= TIMING_48K;
            locked         <= 1'b0;
            changed        <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (clear) begin
                prev_cls  <= TIMING_UNKNOWN;
                match_cnt <= 4'd0;
                locked    <= 1'b0;
            end else if (cls_vld) begin
                prev_cls  <= cls;
                match_cnt <= match_nxt;
                if (lock_hit) begin
                    locked         <= 1'b1;
                    machine_timing <= cls;
                    if (!locked || (machine_timing != cls))
                        changed <= 1'b1;
                end else begin
                    // machine_timing deliberately keeps the last locked class
                    locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/zxvga_porch_detect.sv
// Measures the horizontal front porch (hblank rise to hsync rise) in pixels
// and classifies the source machine timing through a lock filter.
module zxvga_porch_detect
    import zxvga_pkg::*;
#(
    parameter int LOCK_LINES = 4,
    parameter int TOL        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        hblank,
    input  logic        hsync,
    output logic [10:0] fp_count,
    output logic [2:0]  machine_timing,
    output logic        locked,
    output logic        changed
);

    localparam logic signed [FP_W+1:0] TOL_S = (FP_W+2)'(TOL);

    function automatic logic [FP_W-1:0] sat_inc(input logic [FP_W-1:0] v);
        return (v == FP_MAX) ? v : v + 11'd1;
    endfunction

    porch_state_t state;
    porch_state_t state_nxt;

    logic            hblank_q;
    logic            hsync_q;
    logic            hb_rise;
    logic            hb_fall;
    logic            hs_rise;
    logic [FP_W-1:0] porch_cnt;

    logic cnt_clr;
    logic cnt_inc;
    logic meas_take;
    logic meas_zero;
    logic filt_clr;

    logic [2:0] cls_p0;
    logic       vld_p0;
    logic       clr_p0;

    assign hb_rise = pix_ce &  hblank & ~hblank_q;
    assign hb_fall = pix_ce & ~hblank &  hblank_q;
    assign hs_rise = pix_ce &  hsync  & ~hsync_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= WAIT_ACTIVE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        meas_take = 1'b0;
        meas_zero = 1'b0;
        filt_clr  = 1'b0;
        if (pix_ce) begin
            case (state)
                WAIT_ACTIVE: begin
                    if (!hblank)
                        state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (hb_rise) begin
                        // Sync coincident with blank start leaves no porch at all
                        if (hs_rise) begin
                            meas_take = 1'b1;
                            meas_zero = 1'b1;
                            state_nxt = SYNC;
                        end else begin
                            cnt_clr   = 1'b1;
                            state_nxt = PORCH;
                        end
                    end
                end
                PORCH: begin
                    if (hs_rise) begin
                        meas_take = 1'b1;
                        state_nxt = SYNC;
                    end else if (hb_fall) begin
                        filt_clr  = 1'b1;
                        state_nxt = ACTIVE;
                    end else if (!hsync) begin
                        cnt_inc = 1'b1;
                    end
                end
                SYNC: begin
                    if (hb_fall)
                        state_nxt = ACTIVE;
                end
                default: state_nxt = WAIT_ACTIVE;
            endcase
        end
    end

    // Stage p0: edge history, porch counter, measurement latch and class
    always_ff @(posedge clk) begin
        if (reset) begin
            hblank_q  <= 1'b0;
            hsync_q   <= 1'b0;
            porch_cnt <= '0;
            fp_count  <= '0;
            cls_p0    <= TIMING_UNKNOWN;
            vld_p0    <= 1'b0;
            clr_p0    <= 1'b0;
        end else begin
            if (pix_ce) begin
                hblank_q <= hblank;
                hsync_q  <= hsync;
            end
            if (cnt_clr)
                porch_cnt <= 11'd1;
            else if (cnt_inc)
                porch_cnt <= sat_inc(porch_cnt);
            vld_p0 <= meas_take;
            clr_p0 <= filt_clr;
            if (meas_take) begin
                fp_count <= meas_zero ? '0 : porch_cnt;
                cls_p0   <= meas_zero ? TIMING_UNKNOWN : classify_fp(porch_cnt, TOL_S);
            end
        end
    end

    // Stage p1: lock filter
    zxvga_lock_filter #(
        .LOCK_LINES (LOCK_LINES)
    ) u_lock_filter (
        .clk            (clk),
        .reset          (reset),
        .cls            (cls_p0),
        .cls_vld        (vld_p0),
        .clear          (clr_p0),
        .machine_timing (machine_timing),
        .locked         (locked),
        .changed        (changed)
    );

endmodule
